// File: rtl/alu_seq_pkg.sv
// Shared op-code constants, controller state type and small helpers for alu_seq_ctrl.
package alu_seq_pkg;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SHL  = 3'b101;
    localparam logic [2:0] OP_SHR  = 3'b110;
    localparam logic [2:0] OP_XNOR = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_shift(input logic [2:0] op);
        return (op == OP_SHL) || (op == OP_SHR);
    endfunction

endpackage

// File: rtl/alu_seq_cnt.sv
// Loadable down-counter tracking the remaining EXEC cycles of the current command.
module alu_seq_cnt #(
    parameter int unsigned SHW = 5
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic           i_load,
    input  logic [SHW-1:0] i_load_val,
    input  logic           i_dec,
    output logic [SHW-1:0] o_count,
    output logic           o_is_one
);

    logic [SHW-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - SHW'(1);
        end
    end

    assign o_count  = r_count;
    assign o_is_one = (r_count == SHW'(1));

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencing controller for an external combinational ALU (one shift bit per cycle).
// Optional macro ALU_SEQ_PERF_EN adds the saturating o_perf_ops handshake counter.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_cmd_valid,
    output logic                     o_cmd_ready,
    input  logic [2:0]               i_cmd_op,
    input  logic [WIDTH-1:0]         i_cmd_a,
    input  logic [WIDTH-1:0]         i_cmd_b,
    input  logic [$clog2(WIDTH)-1:0] i_cmd_shamt,
    output logic [2:0]               o_alu_select,
    output logic [WIDTH-1:0]         o_alu_a,
    output logic [WIDTH-1:0]         o_alu_b,
    input  logic [WIDTH-1:0]         i_alu_y,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [WIDTH-1:0]         o_rsp_data,
    output logic                     o_rsp_zero,
    output logic                     o_busy
`ifdef ALU_SEQ_PERF_EN
    ,
    output logic [15:0]              o_perf_ops
`endif
);

    localparam int unsigned SHW = $clog2(WIDTH);

    state_t           r_state;
    state_t           w_state_next;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;

    logic             w_accept;
    logic             w_rsp_hs;
    logic [SHW-1:0]   w_cnt_init;
    logic [SHW-1:0]   w_count;
    logic             w_cnt_is_one;

    assign w_accept   = i_cmd_valid && (r_state == IDLE);
    assign w_rsp_hs   = i_rsp_ready && (r_state == DONE);
    assign w_cnt_init = is_shift(i_cmd_op) ? i_cmd_shamt : SHW'(1);

    alu_seq_cnt #(
        .SHW (SHW)
    ) u_cnt (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (w_accept),
        .i_load_val (w_cnt_init),
        .i_dec      (r_state == EXEC),
        .o_count    (w_count),
        .o_is_one   (w_cnt_is_one)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_op    <= OP_NOP;
            r_b     <= '0;
            r_acc   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_op  <= i_cmd_op;
                r_b   <= i_cmd_b;
                r_acc <= i_cmd_a;
            end else if (r_state == EXEC) begin
                r_acc <= i_alu_y;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_cmd_ready  = 1'b0;
        o_rsp_valid  = 1'b0;
        o_busy       = 1'b1;
        o_alu_select = OP_NOP;
        o_alu_a      = '0;
        o_alu_b      = '0;
        unique case (r_state)
            IDLE: begin
                o_cmd_ready = 1'b1;
                o_busy      = 1'b0;
                // A shift by zero has nothing to execute; present cmd_a directly.
                if (w_accept) begin
                    w_state_next = (w_cnt_init == '0) ? DONE : EXEC;
                end
            end
            EXEC: begin
                o_alu_select = r_op;
                o_alu_a      = r_acc;
                o_alu_b      = r_b;
                if (w_cnt_is_one) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // The accumulator only moves in EXEC or on accept, so it is stable throughout DONE.
    assign o_rsp_data = r_acc;
    assign o_rsp_zero = (r_acc == '0);

`ifdef ALU_SEQ_PERF_EN
    logic [15:0] r_perf_ops;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_perf_ops <= '0;
        end else if (w_rsp_hs && (r_perf_ops != 16'hFFFF)) begin
            r_perf_ops <= r_perf_ops + 16'd1;
        end
    end

    assign o_perf_ops = r_perf_ops;
`else
    logic w_unused;
    assign w_unused = w_rsp_hs ^ (^w_count);
`endif

endmodule
